// File: rtl/mem_arbiter.sv
// N-port arbiter sharing one mem_read/mem_write/mem_resp port among several masters.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module mem_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [NUM_PORTS-1:0]                      req_read,
  input  logic [NUM_PORTS-1:0]                      req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]           req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]           req_wdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]       req_byte_enable,
  output logic [NUM_PORTS-1:0]                      req_resp,
  output logic [DATA_WIDTH-1:0]                     req_rdata,
  output logic                                      mem_read,
  output logic                                      mem_write,
  output logic [ADDR_WIDTH-1:0]                     mem_address,
  output logic [DATA_WIDTH-1:0]                     mem_wdata,
  output logic [(DATA_WIDTH/8)-1:0]                 mem_byte_enable,
  input  logic                                      mem_resp,
  input  logic [DATA_WIDTH-1:0]                     mem_rdata,
  output logic                                      grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0]              grant_id
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDW      = $clog2(NUM_PORTS);
  localparam int unsigned PW       = IDW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [IDW-1:0]   start;
  logic [NUM_PORTS-1:0] pending;
  logic [IDW-1:0]   winner;
  logic             found;
  logic [PW-1:0]    idx;

  assign pending = req_read | req_write;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [IDW-1:0] rr_q, rr_d;

  assign start = rr_q;

  // Pointer moves just past the port that completed, wrapping explicitly
  always_comb begin
    rr_d = rr_q;
    if (state_q == BUSY && mem_resp) begin
      rr_d = (grant_q == IDW'(NUM_PORTS - 1)) ? '0 : grant_q + IDW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end
`endif

  // First pending port scanning from start, modulo NUM_PORTS
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      idx = PW'(start) + PW'(k);
      if (idx >= PW'(NUM_PORTS)) idx = idx - PW'(NUM_PORTS);
      if (!found && pending[idx[IDW-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    req_resp        = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = winner;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A simultaneous read+write forwards only the write
        mem_write       = req_write[grant_q];
        mem_read        = req_read[grant_q] & ~req_write[grant_q];
        mem_address     = req_address[32'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
        mem_wdata       = req_wdata[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
        mem_byte_enable = req_byte_enable[32'(grant_q)*BE_WIDTH +: BE_WIDTH];
        if (mem_resp) begin
          req_resp[grant_q] = 1'b1;
          state_d           = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  assign req_rdata   = mem_rdata;
  assign grant_valid = (state_q == BUSY);
  assign grant_id    = grant_q;

endmodule
